// File: rtl/perf_monitor_unit.sv
// Performance monitor: counts run cycles and event strobes up to a cycle limit,
// then streams an atomic snapshot of all counters over a valid/ready port.
module perf_monitor_unit #(
    parameter int NUM_EVT   = 4,
    parameter int CNT_W     = 32,
    parameter int CYC_LIMIT = 70,
    parameter bit SATURATE  = 1'b1,
    localparam int IDX_W    = $clog2(NUM_EVT + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               clear_i,
    input  logic [NUM_EVT-1:0] evt_i,
    input  logic               snap_i,
    output logic               rd_valid_o,
    input  logic               rd_ready_i,
    output logic [IDX_W-1:0]   rd_idx_o,
    output logic [CNT_W-1:0]   rd_data_o,
    output logic               rd_last_o,
    output logic [CNT_W-1:0]   cycle_o,
    output logic               done_o,
    output logic [NUM_EVT:0]   ovf_o,
    output logic               snap_drop_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic RD_IDLE = 1'b0;
    localparam logic RD_SEND = 1'b1;
    localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(CYC_LIMIT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_EVT);

    logic [1:0]       run_q;
    logic             rd_q;
    logic [IDX_W-1:0] idx_q;
    logic [CNT_W-1:0] cnt_q    [NUM_EVT+1];
    logic [CNT_W-1:0] cnt_d    [NUM_EVT+1];
    logic [CNT_W-1:0] shadow_q [NUM_EVT+1];
    logic [NUM_EVT:0] ovf_q, ovf_d;
    logic             drop_q, auto_pend_q;
    logic             cnt_en, going_done, snap_take;
    logic [CNT_W:0]   step;

    // Returns {overflow, next value}; at all-ones either hold or wrap.
    function automatic logic [CNT_W:0] inc_cnt(input logic [CNT_W-1:0] v);
        if (&v)
            return SATURATE ? {1'b1, v} : {1'b1, {CNT_W{1'b0}}};
        return {1'b0, v + CNT_W'(1)};
    endfunction

    assign cnt_en = (run_q == RUN) && start_i;

    always_comb begin
        ovf_d = ovf_q;
        step  = '0;
        for (int k = 0; k <= NUM_EVT; k++) cnt_d[k] = cnt_q[k];
        if (cnt_en) begin
            step     = inc_cnt(cnt_q[0]);
            cnt_d[0] = step[CNT_W-1:0];
            ovf_d[0] = ovf_q[0] | step[CNT_W];
            for (int k = 0; k < NUM_EVT; k++) begin
                if (evt_i[k]) begin
                    step         = inc_cnt(cnt_q[k+1]);
                    cnt_d[k+1]   = step[CNT_W-1:0];
                    ovf_d[k+1]   = ovf_q[k+1] | step[CNT_W];
                end
            end
        end
    end

    // The snapshot copies next-state values so same-cycle increments are included.
    assign going_done = cnt_en && (CYC_LIMIT != 0) && (cnt_d[0] == LIMIT);
    assign snap_take  = (rd_q == RD_IDLE) && !clear_i &&
                        (snap_i || auto_pend_q || going_done);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            run_q       <= IDLE;
            rd_q        <= RD_IDLE;
            idx_q       <= '0;
            ovf_q       <= '0;
            drop_q      <= 1'b0;
            auto_pend_q <= 1'b0;
            for (int k = 0; k <= NUM_EVT; k++) cnt_q[k] <= '0;
        end else if (clear_i) begin
            run_q       <= IDLE;
            rd_q        <= RD_IDLE;
            idx_q       <= '0;
            ovf_q       <= '0;
            drop_q      <= 1'b0;
            auto_pend_q <= 1'b0;
            for (int k = 0; k <= NUM_EVT; k++) cnt_q[k] <= '0;
        end else begin
            for (int k = 0; k <= NUM_EVT; k++) cnt_q[k] <= cnt_d[k];
            ovf_q <= ovf_d;
            case (run_q)
                IDLE:    if (start_i) run_q <= RUN;
                RUN:     if (going_done) run_q <= DONE;
                DONE:    ;
                default: run_q <= IDLE;
            endcase
            if (rd_q == RD_IDLE) begin
                if (snap_take) begin
                    rd_q        <= RD_SEND;
                    idx_q       <= '0;
                    auto_pend_q <= 1'b0;
                end
            end else begin
                // Busy: user requests are dropped, the end-of-run request waits.
                if (snap_i)     drop_q      <= 1'b1;
                if (going_done) auto_pend_q <= 1'b1;
                if (rd_ready_i) begin
                    if (idx_q == LAST_IDX) begin
                        rd_q  <= RD_IDLE;
                        idx_q <= '0;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int k = 0; k <= NUM_EVT; k++) shadow_q[k] <= '0;
        end else if (snap_take) begin
            for (int k = 0; k <= NUM_EVT; k++) shadow_q[k] <= cnt_d[k];
        end
    end

    assign rd_valid_o  = (rd_q == RD_SEND);
    assign rd_idx_o    = idx_q;
    assign rd_data_o   = rd_valid_o ? shadow_q[idx_q] : '0;
    assign rd_last_o   = rd_valid_o && (idx_q == LAST_IDX);
    assign cycle_o     = cnt_q[0];
    assign done_o      = (run_q == DONE);
    assign ovf_o       = ovf_q;
    assign snap_drop_o = drop_q;

endmodule

// File: tb/tb_perf_monitor_unit.sv
// Directed bench for perf_monitor_unit: run limit, readout handshake, overflow,
// snapshot drop, clear priority and asynchronous reset.
module tb_perf_monitor_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, clear = 1'b0, snap = 1'b0, ready = 1'b1;
    logic [3:0]  evt = '0;
    logic        rd_valid, rd_last, done, snap_drop;
    logic [2:0]  rd_idx;
    logic [31:0] rd_data, cycle;
    logic [4:0]  ovf;

    logic        start8 = 1'b0, snap8 = 1'b0;
    logic [3:0]  evt8 = '0;
    logic        s8_valid, s8_last, s8_done, s8_drop;
    logic [2:0]  s8_idx;
    logic [7:0]  s8_data, s8_cycle;
    logic [4:0]  s8_ovf;
    logic        w8_valid, w8_last, w8_done, w8_drop;
    logic [2:0]  w8_idx;
    logic [7:0]  w8_data, w8_cycle;
    logic [4:0]  w8_ovf;

    int          n_chk = 0, n_pass = 0;
    int          n_got;
    logic [63:0] got_idx [8], got_data [8], got_last [8];
    logic [63:0] exp_data [5];

    always #5 clk = ~clk;

    perf_monitor_unit dut (
        .clk_i(clk), .rst_i(rst_n), .start_i(start), .clear_i(clear), .evt_i(evt),
        .snap_i(snap), .rd_valid_o(rd_valid), .rd_ready_i(ready), .rd_idx_o(rd_idx),
        .rd_data_o(rd_data), .rd_last_o(rd_last), .cycle_o(cycle), .done_o(done),
        .ovf_o(ovf), .snap_drop_o(snap_drop)
    );

    perf_monitor_unit #(.CNT_W(8), .CYC_LIMIT(0), .SATURATE(1'b1)) dut_s8 (
        .clk_i(clk), .rst_i(rst_n), .start_i(start8), .clear_i(1'b0), .evt_i(evt8),
        .snap_i(snap8), .rd_valid_o(s8_valid), .rd_ready_i(1'b1), .rd_idx_o(s8_idx),
        .rd_data_o(s8_data), .rd_last_o(s8_last), .cycle_o(s8_cycle), .done_o(s8_done),
        .ovf_o(s8_ovf), .snap_drop_o(s8_drop)
    );

    perf_monitor_unit #(.CNT_W(8), .CYC_LIMIT(0), .SATURATE(1'b0)) dut_w8 (
        .clk_i(clk), .rst_i(rst_n), .start_i(start8), .clear_i(1'b0), .evt_i(evt8),
        .snap_i(snap8), .rd_valid_o(w8_valid), .rd_ready_i(1'b1), .rd_idx_o(w8_idx),
        .rd_data_o(w8_data), .rd_last_o(w8_last), .cycle_o(w8_cycle), .done_o(w8_done),
        .ovf_o(w8_ovf), .snap_drop_o(w8_drop)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Accepts words with ready high until the last one or a cycle budget runs out.
    task automatic collect();
        bit fin = 1'b0;
        n_got = 0;
        ready = 1'b1;
        for (int c = 0; c < 30 && !fin; c++) begin
            if (rd_valid) begin
                if (n_got < 8) begin
                    got_idx[n_got]  = 64'(rd_idx);
                    got_data[n_got] = 64'(rd_data);
                    got_last[n_got] = 64'(rd_last);
                end
                n_got++;
                if (rd_last) fin = 1'b1;
            end
            tick();
        end
        if (!fin) chk("collect_timeout", 0, 1);
    endtask

    task automatic check_stream(input string tag, input int first);
        chk($sformatf("%s_nwords", tag), 64'(n_got), 64'(5 - first));
        for (int i = 0; i < n_got && i < 5 - first; i++) begin
            chk($sformatf("%s_idx%0d", tag, i), got_idx[i], 64'(first + i));
            chk($sformatf("%s_data%0d", tag, first + i), got_data[i], exp_data[first + i]);
            chk($sformatf("%s_last%0d", tag, first + i), got_last[i], 64'(first + i == 4));
        end
    endtask

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_cycle", cycle, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", rd_valid, 0);
        chk("rst_idx", rd_idx, 0);
        chk("rst_data", rd_data, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_drop", snap_drop, 0);

        // Run to the 70-cycle limit with evt[0] every third counted cycle
        rst_n = 1'b1;
        start = 1'b1;
        tick();
        chk("start_no_count", cycle, 0);
        for (int n = 0; n < 70; n++) begin
            evt[0] = (n % 3 == 0);
            if (n == 69) begin
                chk("pre_limit_cycle", cycle, 69);
                chk("pre_limit_done", done, 0);
            end
            tick();
        end
        evt = '0;
        chk("limit_cycle", cycle, 70);
        chk("limit_done", done, 1);
        exp_data[0] = 70; exp_data[1] = 24; exp_data[2] = 0; exp_data[3] = 0; exp_data[4] = 0;
        collect();
        check_stream("auto", 0);
        evt = 4'hF;
        tick();
        evt = '0;
        chk("done_frozen", cycle, 70);
        chk("done_ovf", ovf, 0);

        // Readout stalled for three cycles on word 1
        snap = 1'b1; tick(); snap = 1'b0;
        chk("snap_idx0", rd_idx, 0);
        tick();
        ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            tick();
            chk($sformatf("stall_valid%0d", s), rd_valid, 1);
            chk($sformatf("stall_idx%0d", s), rd_idx, 1);
            chk($sformatf("stall_data%0d", s), rd_data, 24);
        end
        collect();
        check_stream("stall", 1);

        // Second snap request while busy is dropped
        snap = 1'b1; tick(); snap = 1'b0;
        tick(); tick();
        chk("drop_pre", snap_drop, 0);
        chk("drop_at_idx2", rd_idx, 2);
        snap = 1'b1; tick(); snap = 1'b0;
        chk("drop_flag", snap_drop, 1);
        collect();
        check_stream("drop", 3);
        tick();
        chk("drop_no_restart", rd_valid, 0);

        // clear_i beats events, snap_i and a readout in progress
        snap = 1'b1; tick(); snap = 1'b0;
        chk("clr_busy", rd_valid, 1);
        clear = 1'b1; evt = 4'hF; snap = 1'b1; start = 1'b1;
        tick();
        clear = 1'b0; evt = '0; snap = 1'b0;
        chk("clr_cycle", cycle, 0);
        chk("clr_done", done, 0);
        chk("clr_valid", rd_valid, 0);
        chk("clr_drop", snap_drop, 0);
        tick();
        chk("clr_idle_no_count", cycle, 0);
        chk("clr_no_snap", rd_valid, 0);
        tick();
        chk("clr_run_count", cycle, 1);
        start = 1'b0; tick(); tick();
        chk("pause_hold", cycle, 1);
        start = 1'b1; tick();
        chk("pause_resume", cycle, 2);

        // Async reset in DONE with a readout in progress
        for (int c = 0; c < 100 && !done; c++) tick();
        chk("rerun_done", done, 1);
        chk("rerun_cycle", cycle, 70);
        ready = 1'b1;
        tick();
        chk("mid_read_idx", rd_idx, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", rd_valid, 0);
        chk("arst_done", done, 0);
        chk("arst_cycle", cycle, 0);
        chk("arst_idx", rd_idx, 0);
        chk("arst_data", rd_data, 0);
        #2 rst_n = 1'b1;
        start = 1'b1; evt = '0;
        tick();
        chk("restart_cycle0", cycle, 0);
        evt[2] = 1'b1;
        tick(); tick();
        chk("restart_cycle2", cycle, 2);
        snap = 1'b1; tick();
        snap = 1'b0; start = 1'b0; evt = '0;
        exp_data[0] = 3; exp_data[1] = 0; exp_data[2] = 0; exp_data[3] = 3; exp_data[4] = 0;
        collect();
        check_stream("restart", 0);

        // 8-bit counters: saturate versus wrap
        rst_n = 1'b0; tick(); tick(); rst_n = 1'b1;
        start8 = 1'b1;
        tick();
        evt8 = 4'b0010;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (i == 254) begin
                chk("s8_cyc255", s8_cycle, 255);
                chk("s8_ovf_pre", s8_ovf, 0);
                chk("w8_cyc255", w8_cycle, 255);
                chk("w8_ovf_pre", w8_ovf, 0);
            end
            if (i == 255) begin
                chk("s8_cyc_hold", s8_cycle, 255);
                chk("s8_ovf_first", s8_ovf, 5'b00101);
                chk("w8_cyc_wrap", w8_cycle, 0);
                chk("w8_ovf_wrap", w8_ovf, 5'b00101);
            end
        end
        start8 = 1'b0; evt8 = '0; snap8 = 1'b1;
        tick();
        snap8 = 1'b0;
        tick(); tick();
        chk("s8_idx", s8_idx, 2);
        chk("s8_evt1", s8_data, 255);
        chk("s8_ovf", s8_ovf, 5'b00101);
        chk("w8_idx", w8_idx, 2);
        chk("w8_evt1", w8_data, 44);
        chk("w8_ovf", w8_ovf, 5'b00101);
        chk("w8_cycle", w8_cycle, 44);
        chk("w8_valid", w8_valid, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
